serial_word_tx: RTL and testbench

SERIAL_WORD_TX -- requirements
Module: serial_word_tx

---
 rtl/serial_word_tx_if.sv | 13 +
 rtl/serial_word_tx.sv | 65 ++++++
 tb/tb_serial_word_tx.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/serial_word_tx_if.sv
// serial_word_tx_if: word handshake in, framed bit stream out
interface serial_word_tx_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0] din;
  logic din_valid;
  logic din_ready;
  logic bit_out;
  logic bit_valid;
  logic frame_start;
  logic frame_end;
  logic busy;
  modport master (output din, din_valid, input din_ready, bit_out, bit_valid, frame_start, frame_end, busy);
  modport slave (input din, din_valid, output din_ready, bit_out, bit_valid, frame_start, frame_end, busy);
endinterface

// File: rtl/serial_word_tx.sv
// serial_word_tx: serialises a parallel word into a framed bit stream with optional even parity and idle gap
module serial_word_tx #(
  parameter int WIDTH = 8,
  parameter bit MSB_FIRST = 1,
  parameter bit APPEND_PARITY = 1,
  parameter int GAP = 0
) (
  input logic clk,
  input logic rst_n,
  serial_word_tx_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [3:0] GLAST = 4'(GAP > 0 ? GAP - 1 : 0);
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_PARITY, S_GAP} state_t;
  state_t state_q;
  logic [WIDTH-1:0] sh_q;
  logic [CW-1:0] cnt_q;
  logic [3:0] gcnt_q;
  logic par_q;
  logic head;
  state_t after_par, after_data;
  assign head = MSB_FIRST ? sh_q[WIDTH-1] : sh_q[0];
  assign after_par = GAP > 0 ? S_GAP : S_IDLE;
  assign after_data = APPEND_PARITY ? S_PARITY : after_par;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= S_IDLE;
      sh_q <= '0;
      cnt_q <= '0;
      gcnt_q <= '0;
      par_q <= 1'b0;
    end else
      case (state_q)
        S_IDLE: if (bus.din_valid) begin
          sh_q <= bus.din;
          cnt_q <= '0;
          par_q <= 1'b0;
          state_q <= S_SHIFT;
        end
        S_SHIFT: begin
          sh_q <= MSB_FIRST ? {sh_q[WIDTH-2:0], 1'b0} : {1'b0, sh_q[WIDTH-1:1]};
          par_q <= par_q ^ head;
          cnt_q <= cnt_q + 1'b1;
          gcnt_q <= '0;
          if (cnt_q == LAST) state_q <= after_data;
        end
        S_PARITY: begin
          gcnt_q <= '0;
          state_q <= after_par;
        end
        S_GAP: begin
          gcnt_q <= gcnt_q + 1'b1;
          if (gcnt_q == GLAST) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
  // outputs are pure decodes of registered state, so reset clears them without a clock
  assign bus.din_ready = state_q == S_IDLE;
  assign bus.busy = state_q != S_IDLE;
  assign bus.bit_valid = state_q == S_SHIFT || state_q == S_PARITY;
  assign bus.bit_out = state_q == S_SHIFT ? head : (state_q == S_PARITY && par_q);
  assign bus.frame_start = state_q == S_SHIFT && cnt_q == '0;
  assign bus.frame_end = state_q == S_PARITY || (!APPEND_PARITY && state_q == S_SHIFT && cnt_q == LAST);
endmodule

// File: tb/tb_serial_word_tx.sv
// tb_serial_word_tx: table vectors, corner sequences and random words across four parameter sets
module tb_serial_word_tx;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_t = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int pw[4] = '{8, 8, 8, 2};
  int pm[4] = '{1, 0, 1, 1};
  int pa[4] = '{1, 0, 1, 1};
  int pg[4] = '{0, 0, 3, 0};
  logic [31:0] dn[4];
  logic dv[4];
  wire [5:0] ob[4];
  serial_word_tx_if #(.WIDTH(8)) i0 ();
  serial_word_tx_if #(.WIDTH(8)) i1 ();
  serial_word_tx_if #(.WIDTH(8)) i2 ();
  serial_word_tx_if #(.WIDTH(2)) i3 ();
  assign i0.din = dn[0][7:0];
  assign i1.din = dn[1][7:0];
  assign i2.din = dn[2][7:0];
  assign i3.din = dn[3][1:0];
  assign i0.din_valid = dv[0];
  assign i1.din_valid = dv[1];
  assign i2.din_valid = dv[2];
  assign i3.din_valid = dv[3];
  assign ob[0] = {i0.bit_valid, i0.bit_out, i0.frame_start, i0.frame_end, i0.busy, i0.din_ready};
  assign ob[1] = {i1.bit_valid, i1.bit_out, i1.frame_start, i1.frame_end, i1.busy, i1.din_ready};
  assign ob[2] = {i2.bit_valid, i2.bit_out, i2.frame_start, i2.frame_end, i2.busy, i2.din_ready};
  assign ob[3] = {i3.bit_valid, i3.bit_out, i3.frame_start, i3.frame_end, i3.busy, i3.din_ready};
  serial_word_tx #(.WIDTH(8)) u0 (.clk(clk), .rst_n(rst_n), .bus(i0.slave));
  serial_word_tx #(.WIDTH(8), .MSB_FIRST(0), .APPEND_PARITY(0)) u1 (.clk(clk), .rst_n(rst_n), .bus(i1.slave));
  serial_word_tx #(.WIDTH(8), .GAP(3)) u2 (.clk(clk), .rst_n(rst_n), .bus(i2.slave));
  serial_word_tx #(.WIDTH(2)) u3 (.clk(clk), .rst_n(rst_n), .bus(i3.slave));
  typedef struct {
    int k;
    logic [31:0] w;
    logic [31:0] eb;
    logic ep;
  } vec_t;
  vec_t tbl[$];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at t=%0t", nm, act, exp, $time);
    end
  endtask
  function automatic logic [31:0] mbits(input int k, input logic [31:0] w);
    logic [31:0] r = '0;
    for (int i = 0; i < pw[k]; i++) r[i] = pm[k] != 0 ? w[pw[k]-1-i] : w[i];
    return r;
  endfunction
  function automatic logic mpar(input int k, input logic [31:0] w);
    return ^(w & ((32'd1 << pw[k]) - 1));
  endfunction
  // output vector order: {bit_valid, bit_out, frame_start, frame_end, busy, din_ready}
  task automatic frame(input int k, input logic [31:0] w, input logic [31:0] nxt, input bit hold, input bit sp,
                       input int pulse, input logic [31:0] eb, input logic ep);
    int n = pw[k] + pa[k];
    int l = n + pg[k];
    int t;
    logic [5:0] e;
    @(negedge clk);
    chk($sformatf("idle_before k%0d w=%h", k, w), ob[k], 6'b000001);
    dn[k] = w;
    dv[k] = 1'b1;
    for (int c = 1; c <= l; c++) begin
      @(negedge clk);
      if (c == 1) begin
        t = cyc;
        if (sp) chk($sformatf("accept_spacing k%0d", k), t - last_t, l + 1);
        last_t = t;
        if (hold) dn[k] = nxt;
        else dv[k] = 1'b0;
      end
      if (pulse != 0 && c == pulse) begin
        dn[k] = 32'h3C;
        dv[k] = 1'b1;
      end
      if (pulse != 0 && c == pulse + 1) dv[k] = 1'b0;
      e = c <= n ? {1'b1, c <= pw[k] ? eb[c-1] : ep, c == 1, c == n, 2'b10} : 6'b000010;
      chk($sformatf("frame k%0d w=%h cyc%0d", k, w, c), ob[k], e);
    end
  endtask
  task automatic idle(input int k, input int n);
    repeat (n) begin
      @(negedge clk);
      chk($sformatf("stay_idle k%0d", k), ob[k], 6'b000001);
    end
  endtask
  initial begin
    int k;
    logic [31:0] w;
    for (int i = 0; i < 4; i++) begin
      dn[i] = '0;
      dv[i] = 1'b0;
    end
    tbl.push_back('{0, 32'hA5, 32'hA5, 1'b0});
    tbl.push_back('{0, 32'h81, 32'h81, 1'b0});
    tbl.push_back('{0, 32'h3C, 32'h3C, 1'b0});
    tbl.push_back('{0, 32'h07, 32'hE0, 1'b1});
    tbl.push_back('{1, 32'h01, 32'h01, 1'b0});
    tbl.push_back('{1, 32'h80, 32'h80, 1'b0});
    tbl.push_back('{1, 32'hB2, 32'hB2, 1'b0});
    tbl.push_back('{2, 32'hFF, 32'hFF, 1'b0});
    tbl.push_back('{3, 32'h1, 32'h2, 1'b1});
    tbl.push_back('{3, 32'h2, 32'h1, 1'b1});
    #12;
    for (int i = 0; i < 4; i++) chk($sformatf("reset_state k%0d", i), ob[i], 6'b000001);
    @(negedge clk);
    rst_n = 1'b1;
    foreach (tbl[i]) frame(tbl[i].k, tbl[i].w, 0, 1'b0, 1'b0, 0, tbl[i].eb, tbl[i].ep);
    frame(2, 32'hFF, 32'h00, 1'b1, 1'b0, 0, 32'hFF, 1'b0);
    frame(2, 32'h00, 32'h00, 1'b0, 1'b1, 0, 32'h00, 1'b0);
    frame(3, 32'h0, 32'h1, 1'b1, 1'b0, 0, 32'h0, 1'b0);
    frame(3, 32'h1, 32'h2, 1'b1, 1'b1, 0, 32'h2, 1'b1);
    frame(3, 32'h2, 32'h3, 1'b1, 1'b1, 0, 32'h1, 1'b1);
    frame(3, 32'h3, 32'h0, 1'b0, 1'b1, 0, 32'h3, 1'b0);
    frame(0, 32'hA5, 0, 1'b0, 1'b0, 4, 32'hA5, 1'b0);
    idle(0, 4);
    @(negedge clk);
    dn[0] = 32'h5A;
    dv[0] = 1'b1;
    @(negedge clk);
    dv[0] = 1'b0;
    repeat (4) @(negedge clk);
    chk("fifth_bit_before_reset", ob[0], 6'b110010);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_midframe", ob[0], 6'b000001);
    @(negedge clk);
    rst_n = 1'b1;
    frame(0, 32'h81, 0, 1'b0, 1'b0, 0, 32'h81, 1'b0);
    repeat (40) begin
      k = int'($urandom_range(0, 3));
      w = $urandom & ((32'd1 << pw[k]) - 1);
      frame(k, w, 0, 1'b0, 1'b0, 0, mbits(k, w), mpar(k, w));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
